// File: rtl/ray_sphere_pipe.sv
// Four-stage ray/sphere intersection pipeline: exact integer quarter-discriminant
// h*h - a*c with per-stage valid bits, collapsing bubbles and full backpressure.
module ray_sphere_pipe #(
    parameter int W     = 32,
    parameter int TAG_W = 8,
    localparam int DW   = 4 * W + 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3*W-1:0]   origin,
    input  logic [3*W-1:0]   dir,
    input  logic [3*W-1:0]   center,
    input  logic [W-1:0]     radius,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             hit,
    output logic             graze,
    output logic [DW-1:0]    disc,
    output logic [TAG_W-1:0] out_tag
);
    localparam int OW = W + 1;
    localparam int PW = 2 * W + 4;

    logic v1, v2, v3, v4;
    logic adv1, adv2, adv3, adv4;

    // Each stage moves when it is empty or its successor moves, so bubbles collapse.
    always_comb begin
        adv4     = !v4 || out_ready;
        adv3     = !v3 || adv4;
        adv2     = !v2 || adv3;
        adv1     = !v1 || adv2;
        in_ready = adv1 && !rst;
    end

    assign out_valid = v4;

    logic signed [W-1:0] org_x, org_y, org_z;
    logic signed [W-1:0] dir_x, dir_y, dir_z;
    logic signed [W-1:0] cen_x, cen_y, cen_z;
    logic signed [W-1:0] rad;

    assign org_x = origin[W-1:0];
    assign org_y = origin[2*W-1:W];
    assign org_z = origin[3*W-1:2*W];
    assign dir_x = dir[W-1:0];
    assign dir_y = dir[2*W-1:W];
    assign dir_z = dir[3*W-1:2*W];
    assign cen_x = center[W-1:0];
    assign cen_y = center[2*W-1:W];
    assign cen_z = center[3*W-1:2*W];
    assign rad   = radius;

    // Stage 1: oc = origin - center, one extra bit so the difference never wraps.
    logic signed [OW-1:0] oc1_x, oc1_y, oc1_z;
    logic signed [W-1:0]  d1_x, d1_y, d1_z;
    logic signed [W-1:0]  r1;
    logic [TAG_W-1:0]     tag1;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (adv1) begin
            v1 <= in_valid;
        end
        if (in_ready && in_valid) begin
            oc1_x <= OW'(org_x) - OW'(cen_x);
            oc1_y <= OW'(org_y) - OW'(cen_y);
            oc1_z <= OW'(org_z) - OW'(cen_z);
            d1_x  <= dir_x;
            d1_y  <= dir_y;
            d1_z  <= dir_z;
            r1    <= rad;
            tag1  <= in_tag;
        end
    end

    // Stage 2: three dot products, every operand sign-extended to the full width first.
    logic signed [PW-1:0] a_n, h_n, c_n;
    logic signed [PW-1:0] a2, h2, c2;
    logic [TAG_W-1:0]     tag2;

    always_comb begin
        a_n = PW'(d1_x) * PW'(d1_x)
            + PW'(d1_y) * PW'(d1_y)
            + PW'(d1_z) * PW'(d1_z);
        h_n = PW'(oc1_x) * PW'(d1_x)
            + PW'(oc1_y) * PW'(d1_y)
            + PW'(oc1_z) * PW'(d1_z);
        c_n = PW'(oc1_x) * PW'(oc1_x)
            + PW'(oc1_y) * PW'(oc1_y)
            + PW'(oc1_z) * PW'(oc1_z)
            - PW'(r1) * PW'(r1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else if (adv2) begin
            v2 <= v1;
        end
        if (adv2 && v1) begin
            a2   <= a_n;
            h2   <= h_n;
            c2   <= c_n;
            tag2 <= tag1;
        end
    end

    // Stage 3: the two wide products.
    logic signed [DW-1:0] hh_n, ac_n;
    logic signed [DW-1:0] hh3, ac3;
    logic [TAG_W-1:0]     tag3;

    always_comb begin
        hh_n = DW'(h2) * DW'(h2);
        ac_n = DW'(a2) * DW'(c2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3 <= 1'b0;
        end else if (adv3) begin
            v3 <= v2;
        end
        if (adv3 && v2) begin
            hh3  <= hh_n;
            ac3  <= ac_n;
            tag3 <= tag2;
        end
    end

    // Stage 4: difference and its sign classification; this is the output register.
    logic signed [DW-1:0] disc_n;
    logic                 hit_n, graze_n;

    always_comb begin
        disc_n  = hh3 - ac3;
        graze_n = (disc_n == '0);
        hit_n   = !disc_n[DW-1] && !graze_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v4      <= 1'b0;
            disc    <= '0;
            hit     <= 1'b0;
            graze   <= 1'b0;
            out_tag <= '0;
        end else begin
            if (adv4) begin
                v4 <= v3;
            end
            if (adv4 && v3) begin
                disc    <= disc_n;
                hit     <= hit_n;
                graze   <= graze_n;
                out_tag <= tag3;
            end
        end
    end

endmodule

// File: tb/tb_ray_sphere_pipe.sv
// Directed-vector and streaming bench for ray_sphere_pipe with a wide-integer
// discriminant model and an in-order result scoreboard.
module tb_ray_sphere_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [95:0]  origin, dir, center;
    logic [31:0]  radius;
    logic [7:0]   in_tag;
    logic         out_valid;
    logic         out_ready;
    logic         hit, graze;
    logic [135:0] disc;
    logic [7:0]   out_tag;

    ray_sphere_pipe #(.W(32), .TAG_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .origin(origin), .dir(dir), .center(center), .radius(radius), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .hit(hit), .graze(graze), .disc(disc), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [95:0]  o, d, c;
        logic [31:0]  r;
        logic [7:0]   tag;
        longint       exp_disc;
    } vec_t;

    typedef struct {
        logic signed [255:0] d;
        logic [7:0]          tag;
    } exp_t;

    vec_t   vecs[8];
    exp_t   exp_q[$];
    int     accepted, received, fall_cnt;
    bit     prev_stall;
    logic [135:0] sv_disc;
    logic   sv_hit, sv_graze;
    logic [7:0] sv_tag;

    localparam logic [31:0] MINV = 32'h8000_0000;
    localparam logic [31:0] MAXV = 32'h7fff_ffff;

    function automatic logic [95:0] p3(input int x, input int y, input int z);
        return {z, y, x};
    endfunction

    function automatic logic signed [255:0] ref_disc(input logic [95:0] o, d, c,
                                                     input logic [31:0] r);
        logic signed [255:0] px, py, pz, dx, dy, dz, rr, a, h, cc;
        px = 256'($signed(o[31:0]))  - 256'($signed(c[31:0]));
        py = 256'($signed(o[63:32])) - 256'($signed(c[63:32]));
        pz = 256'($signed(o[95:64])) - 256'($signed(c[95:64]));
        dx = 256'($signed(d[31:0]));
        dy = 256'($signed(d[63:32]));
        dz = 256'($signed(d[95:64]));
        rr = 256'($signed(r));
        a  = dx * dx + dy * dy + dz * dz;
        h  = px * dx + py * dy + pz * dz;
        cc = px * px + py * py + pz * pz - rr * rr;
        return h * h - a * cc;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic signed [255:0] act,
                        input logic signed [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic signed [255:0] got_disc();
        return 256'($signed(disc));
    endfunction

    // One streaming clock: check outputs and record acceptances at the negedge,
    // then return just after the next rising edge so the caller can drive inputs.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (prev_stall) begin
            chk1("stall_valid", out_valid, 1'b1);
            chkw("stall_disc", got_disc(), 256'($signed(sv_disc)));
            chk1("stall_hit", hit, sv_hit);
            chk1("stall_graze", graze, sv_graze);
            chkw("stall_tag", 256'(out_tag), 256'(sv_tag));
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got tag %0d expected no result", out_tag);
            end else begin
                e = exp_q.pop_front();
                chkw("stream_disc", got_disc(), e.d);
                chkw("stream_tag", 256'(out_tag), 256'(e.tag));
                chk1("stream_hit", hit, !e.d[255] && (e.d != '0));
                chk1("stream_graze", graze, e.d == '0);
                received++;
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back('{ref_disc(origin, dir, center, radius), in_tag});
            accepted++;
        end
        if (!in_ready && fall_cnt < 0) fall_cnt = accepted;
        prev_stall = out_valid && !out_ready;
        sv_disc    = disc;
        sv_hit     = hit;
        sv_graze   = graze;
        sv_tag     = out_tag;
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input logic [95:0] o, d, c, input logic [31:0] r,
                              input logic [7:0] t, input logic signed [255:0] e);
        origin = o; dir = d; center = c; radius = r; in_tag = t;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk1("single_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk1("latency_early", out_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk1("latency_valid", out_valid, 1'b1);
        chkw("single_disc", got_disc(), e);
        chk1("single_hit", hit, !e[255] && (e != '0));
        chk1("single_graze", graze, e == '0);
        chkw("single_tag", 256'(out_tag), 256'(t));
        @(posedge clk); #1;
        @(negedge clk);
        chk1("single_drained", out_valid, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic stream_reset();
        accepted = 0; received = 0; fall_cnt = -1; prev_stall = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        vecs[0] = '{p3(0,0,0), p3(0,0,-1), p3(0,0,-4),  32'd2,  8'h11, 64'sd4};
        vecs[1] = '{p3(0,0,0), p3(0,0,-1), p3(5,0,-4),  32'd2,  8'h12, -64'sd21};
        vecs[2] = '{p3(0,0,0), p3(0,0,-1), p3(2,0,-4),  32'd2,  8'h13, 64'sd0};
        vecs[3] = '{p3(1,2,3), p3(1,0,0),  p3(1,2,3),   32'd5,  8'h14, 64'sd25};
        vecs[4] = '{p3(3,0,0), p3(0,0,0),  p3(0,0,0),   32'd1,  8'h15, 64'sd0};
        vecs[5] = '{p3(0,0,0), p3(2,3,0),  p3(-1,-1,0), 32'd1,  8'h16, 64'sd12};
        vecs[6] = '{p3(0,0,0), p3(0,0,-1), p3(0,0,-4),  -32'sd2, 8'h17, 64'sd4};
        vecs[7] = '{p3(0,0,0), p3(1,1,1),  p3(10,-10,0), 32'd3, 8'h18, -64'sd573};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        origin = '0; dir = '0; center = '0; radius = '0; in_tag = '0;
        stream_reset();

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_hit", hit, 1'b0);
        chk1("rst_graze", graze, 1'b0);
        chkw("rst_disc", got_disc(), '0);
        chkw("rst_tag", 256'(out_tag), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("post_rst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Directed vectors with hand-computed discriminants.
        for (int i = 0; i < 8; i++)
            run_single(vecs[i].o, vecs[i].d, vecs[i].c, vecs[i].r, vecs[i].tag,
                       256'(vecs[i].exp_disc));

        // Extreme operands against the wide model.
        for (int i = 0; i < 16; i++) begin
            logic [8:0] sel;
            logic [95:0] o, d, c;
            if (i < 8) sel = {{3{i[2]}}, {3{i[1]}}, {3{i[0]}}};
            else       sel = 9'($urandom);
            o = {sel[2] ? MAXV : MINV, sel[1] ? MAXV : MINV, sel[0] ? MAXV : MINV};
            d = {sel[5] ? MAXV : MINV, sel[4] ? MAXV : MINV, sel[3] ? MAXV : MINV};
            c = {sel[8] ? MAXV : MINV, sel[7] ? MAXV : MINV, sel[6] ? MAXV : MINV};
            run_single(o, d, c, MINV, 8'(8'h40 + i), ref_disc(o, d, c, MINV));
        end

        // Backpressure: continuous offers, output blocked for the first 10 cycles.
        stream_reset();
        for (int cyc = 0; cyc < 300 && received < 20; cyc++) begin
            out_ready = (cyc >= 10);
            in_valid  = (accepted < 20);
            origin = p3(accepted, 0, 0); dir = p3(0, 0, -1); center = p3(0, 0, -4);
            radius = 32'd2; in_tag = 8'(accepted);
            cycle();
        end
        in_valid = 1'b0;
        chkw("bp_fall_after", 256'(fall_cnt), 256'(4));
        chkw("bp_received", 256'(received), 256'(20));
        chkw("bp_queue_empty", 256'(exp_q.size()), '0);

        // Random bubbles on both sides.
        stream_reset();
        for (int cyc = 0; cyc < 20000 && received < 1000; cyc++) begin
            in_valid  = (accepted < 1000) && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            if (($urandom_range(0, 3)) == 0) begin
                origin = {$urandom, $urandom, $urandom};
                dir    = {$urandom, $urandom, $urandom};
                center = {$urandom, $urandom, $urandom};
                radius = $urandom;
            end else begin
                origin = p3($urandom_range(0, 20) - 10, $urandom_range(0, 20) - 10, $urandom_range(0, 20) - 10);
                dir    = p3($urandom_range(0, 6) - 3, $urandom_range(0, 6) - 3, $urandom_range(0, 6) - 3);
                center = p3($urandom_range(0, 20) - 10, $urandom_range(0, 20) - 10, $urandom_range(0, 20) - 10);
                radius = 32'($urandom_range(0, 12)) - 32'd6;
            end
            in_tag = 8'(accepted);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chkw("rand_received", 256'(received), 256'(1000));
        chkw("rand_queue_empty", 256'(exp_q.size()), '0);

        // Reset mid-flight: three requests inside, then one reset cycle.
        stream_reset();
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 50 && accepted < 3; cyc++) begin
            in_valid = 1'b1;
            origin = vecs[0].o; dir = vecs[0].d; center = vecs[0].c;
            radius = vecs[0].r; in_tag = 8'(8'h80 + accepted);
            cycle();
        end
        in_valid = 1'b0;
        chkw("mid_accepted", 256'(accepted), 256'(3));
        rst = 1'b1;
        @(negedge clk);
        chk1("mid_rst_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        chk1("mid_rst_out_valid", out_valid, 1'b0);
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk1("mid_post_in_ready", in_ready, 1'b1);
        for (int k = 0; k < 6; k++) begin
            chk1("mid_no_stale", out_valid, 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        stream_reset();
        run_single(vecs[1].o, vecs[1].d, vecs[1].c, vecs[1].r, 8'h99, 256'(vecs[1].exp_disc));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
